valid_src: RTL

VALID_SRC -- requirements
Module: valid_src

---
 rtl/drv_pkg.sv | 12 +
 rtl/rng.sv | 29 ++
 rtl/valid_src.sv | 110 +++++++++++
 3 files changed

// File: rtl/drv_pkg.sv
// Shared types and constants for the valid_src traffic driver.
package drv_pkg;
  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_e;

  localparam int GAP_LEN_W = 3;
  localparam logic [15:0] SAT_MAX = 16'hFFFF;
endpackage

// File: rtl/rng.sv
// Free-running 16-bit Galois LFSR; advances every cycle out of reset.
module rng #(
  parameter int unsigned SEED = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  rnd_8,
  output logic [15:0] rnd_16
);
  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [15:0] INIT =
    (SEED[15:0] == 16'd0) ? 16'd1 : SEED[15:0];

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ 16'hB400;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= INIT;
    else        lfsr_q <= lfsr_d;
  end

  assign rnd_16 = lfsr_q;
  assign rnd_8  = lfsr_q[7:0];
endmodule

// File: rtl/valid_src.sv
// Valid/ready traffic source: emits an incrementing payload for a run
// of num_pkts transfers with random idle gaps, counting stalls.
module valid_src
  import drv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int unsigned SEED = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       num_pkts,
  input  logic [7:0]        gap_thresh,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sent_cnt,
  output logic [15:0]       stall_cnt
);
  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [15:0]            sent_q, sent_d;
  logic [15:0]            stall_q, stall_d;
  logic [15:0]            npkts_q, npkts_d;
  logic [7:0]             thresh_q, thresh_d;
  logic [GAP_LEN_W-1:0]   gap_q, gap_d;
  logic [7:0]             rand_8;
  logic                   xfer;

  rng #(.SEED(SEED)) rng_i (
    .clk    (clk),
    .rst_n  (rst_n),
    .rnd_8  (rand_8),
    .rnd_16 ()
  );

  assign valid     = (state_q == SEND);
  assign busy      = (state_q == SEND) || (state_q == GAP);
  assign done      = (state_q == DONE);
  assign data      = data_q;
  assign sent_cnt  = sent_q;
  assign stall_cnt = stall_q;
  assign xfer      = valid && ready;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sent_d   = sent_q;
    stall_d  = stall_q;
    npkts_d  = npkts_q;
    thresh_d = thresh_q;
    gap_d    = gap_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          npkts_d  = num_pkts;
          thresh_d = gap_thresh;
          data_d   = '0;
          sent_d   = '0;
          stall_d  = '0;
          gap_d    = '0;
          state_d  = (num_pkts != 16'd0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (!ready && stall_q != SAT_MAX)
          stall_d = stall_q + 16'd1;
        if (xfer) begin
          data_d = data_q + DATA_W'(1);
          sent_d = sent_q + 16'd1;
          if (sent_q + 16'd1 == npkts_q) begin
            state_d = DONE;
          end else if (rand_8 > thresh_q &&
                       rand_8[GAP_LEN_W-1:0] != '0) begin
            gap_d   = rand_8[GAP_LEN_W-1:0];
            state_d = GAP;
          end
        end
      end
      GAP: begin
        gap_d = gap_q - GAP_LEN_W'(1);
        if (gap_q == GAP_LEN_W'(1)) state_d = SEND;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      sent_q   <= '0;
      stall_q  <= '0;
      npkts_q  <= '0;
      thresh_q <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sent_q   <= sent_d;
      stall_q  <= stall_d;
      npkts_q  <= npkts_d;
      thresh_q <= thresh_d;
      gap_q    <= gap_d;
    end
  end
endmodule
